// File: rtl/lcd_seq.sv
// lcd_seq: character-LCD write sequencer with power-on init and a 4-deep byte request FIFO.
// Each byte is sent as two 4-bit nibbles on sf_d, with one lcd_e strobe per nibble.
module lcd_seq #(
  parameter int T_PWR   = 750000,
  parameter int T_W1    = 205000,
  parameter int T_W2    = 5000,
  parameter int T_SU    = 2,
  parameter int T_EH    = 12,
  parameter int T_GAP   = 50,
  parameter int T_SHORT = 2000,
  parameter int T_LONG  = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  input  logic       req_long,
  output logic       init_done,
  output logic       busy,
  output logic [3:0] sf_d,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       sf_ceo
);
  typedef enum logic [3:0] {
    PWR_WAIT, INIT_SU, INIT_EH, INIT_WAIT, IDLE,
    HI_SU, HI_EH, GAP, LO_SU, LO_EH, SETTLE
  } state_t;
  state_t      r_state;
  logic [19:0] r_cnt;
  logic        r_armed;
  logic [1:0]  r_idx;
  logic [9:0]  r_hold;
  logic [9:0]  r_mem [4];
  logic [1:0]  r_wp, r_rp;
  logic [2:0]  r_fill;
  logic [3:0]  r_sf_d;
  logic        r_e, r_rs, r_init_done;
  logic        w_empty, w_push, w_pop;
  logic [9:0]  w_head;
  logic [1:0]  w_idx_nxt;
  logic [19:0] w_init_wait;
  assign w_empty     = r_fill == 3'd0;
  assign req_ready   = r_fill != 3'd4;
  assign w_push      = req_valid & req_ready;
  assign w_pop       = !w_empty && r_cnt == 20'd0 && (r_state == IDLE || r_state == SETTLE);
  assign w_head      = r_mem[r_rp];
  assign w_idx_nxt   = r_idx + 2'd1;
  assign w_init_wait = r_idx == 2'd0 ? 20'(T_W1 - 1) :
                       r_idx == 2'd1 ? 20'(T_W2 - 1) : 20'(T_SHORT - 1);
  assign sf_d      = r_sf_d;
  assign lcd_e     = r_e;
  assign lcd_rs    = r_rs;
  assign init_done = r_init_done;
  assign busy      = r_state != IDLE || !w_empty;
  assign lcd_rw    = 1'b0;
  assign sf_ceo    = 1'b0;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= {req_long, req_rs, req_data};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 2'd1;
      if (w_pop) r_rp <= r_rp + 2'd1;
      r_fill <= r_fill + 3'(w_push) - 3'(w_pop);
    end
  end
  // The counter is 0 out of reset, so the first PWR_WAIT cycle arms it to make the wait exactly T_PWR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= PWR_WAIT;
      r_cnt       <= '0;
      r_armed     <= 1'b0;
      r_idx       <= '0;
      r_hold      <= '0;
      r_sf_d      <= '0;
      r_e         <= 1'b0;
      r_rs        <= 1'b0;
      r_init_done <= 1'b0;
    end else if (r_state == PWR_WAIT && !r_armed) begin
      r_armed <= 1'b1;
      r_cnt   <= 20'(T_PWR - 2);
    end else if (r_cnt != 20'd0) begin
      r_cnt <= r_cnt - 20'd1;
    end else begin
      case (r_state)
        PWR_WAIT: begin
          r_state <= INIT_SU;
          r_cnt   <= 20'(T_SU - 1);
          r_sf_d  <= 4'h3;
        end
        INIT_SU: begin
          r_state <= INIT_EH;
          r_cnt   <= 20'(T_EH - 1);
          r_e     <= 1'b1;
        end
        INIT_EH: begin
          r_state <= INIT_WAIT;
          r_cnt   <= w_init_wait;
          r_e     <= 1'b0;
        end
        INIT_WAIT:
          if (r_idx == 2'd3) begin
            r_state     <= IDLE;
            r_init_done <= 1'b1;
          end else begin
            r_state <= INIT_SU;
            r_idx   <= w_idx_nxt;
            r_cnt   <= 20'(T_SU - 1);
            r_sf_d  <= w_idx_nxt == 2'd3 ? 4'h2 : 4'h3;
          end
        HI_SU: begin
          r_state <= HI_EH;
          r_cnt   <= 20'(T_EH - 1);
          r_e     <= 1'b1;
          r_sf_d  <= r_hold[7:4];
          r_rs    <= r_hold[8];
        end
        HI_EH: begin
          r_state <= GAP;
          r_cnt   <= 20'(T_GAP - 1);
          r_e     <= 1'b0;
        end
        GAP: begin
          r_state <= LO_SU;
          r_cnt   <= 20'(T_SU - 1);
          r_sf_d  <= r_hold[3:0];
        end
        LO_SU: begin
          r_state <= LO_EH;
          r_cnt   <= 20'(T_EH - 1);
          r_e     <= 1'b1;
        end
        LO_EH: begin
          r_state <= SETTLE;
          r_cnt   <= r_hold[9] ? 20'(T_LONG - 1) : 20'(T_SHORT - 1);
          r_e     <= 1'b0;
        end
        IDLE, SETTLE:
          if (w_pop) begin
            r_state <= HI_SU;
            r_cnt   <= 20'(T_SU - 1);
            r_hold  <= w_head;
            r_sf_d  <= w_head[7:4];
            r_rs    <= w_head[8];
          end else begin
            r_state <= IDLE;
          end
        default: r_state <= PWR_WAIT;
      endcase
    end
  end
endmodule
